// File: rtl/axis_packet_arbiter.sv
// Round-robin packet arbiter: N AXI-Stream requesters share one output stream.
// A grant is held from the first beat until the tlast handshake of the granted packet.

module axis_pkt_counter #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   inc,
    output logic [COUNT_WIDTH-1:0] count
);
    // Saturate at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + COUNT_WIDTH'(1);
    end
endmodule

module axis_packet_arbiter #(
    parameter int NUM_IN      = 4,
    parameter int TDATA_WIDTH = 32,
    parameter int TDEST_WIDTH = 2,
    parameter int TID_WIDTH   = 2,
    parameter int COUNT_WIDTH = 16,
    localparam int GW         = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   axis_in_tvalid [NUM_IN],
    output logic                   axis_in_tready [NUM_IN],
    input  logic                   axis_in_tlast  [NUM_IN],
    input  logic [TDATA_WIDTH-1:0] axis_in_tdata  [NUM_IN],
    input  logic [TDEST_WIDTH-1:0] axis_in_tdest  [NUM_IN],
    input  logic [TID_WIDTH-1:0]   axis_in_tid    [NUM_IN],
    output logic                   axis_out_tvalid,
    input  logic                   axis_out_tready,
    output logic [TDATA_WIDTH-1:0] axis_out_tdata,
    output logic                   axis_out_tlast,
    output logic [TDEST_WIDTH-1:0] axis_out_tdest,
    output logic [TID_WIDTH-1:0]   axis_out_tid,
    output logic [GW-1:0]          grant_id,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] pkt_count [NUM_IN]
);
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   ptr_q, ptr_d;
    logic            arb_en_q;
    logic            sel_found;
    logic [GW-1:0]   sel_idx;
    logic            locked;
    logic            tlast_hs;

    assign locked   = (state_q == LOCKED);
    assign tlast_hs = locked && axis_in_tvalid[grant_q] && axis_out_tready
                      && axis_in_tlast[grant_q];

    // First valid requester at or after ptr, wrapping modulo NUM_IN.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (!sel_found && axis_in_tvalid[(int'(ptr_q) + i) % NUM_IN]) begin
                sel_found = 1'b1;
                sel_idx   = GW'((int'(ptr_q) + i) % NUM_IN);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (arb_en_q && sel_found) begin
                    state_d = LOCKED;
                    grant_d = sel_idx;
                end
            end
            LOCKED: begin
                if (tlast_hs) begin
                    state_d = IDLE;
                    ptr_d   = GW'((int'(grant_q) + 1) % NUM_IN);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // arb_en_q keeps the first edge after reset release grant-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            ptr_q    <= '0;
            arb_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            arb_en_q <= 1'b1;
        end
    end

    // Ready depends only on state, grant and downstream ready, never on tvalid.
    always_comb begin
        for (int i = 0; i < NUM_IN; i++)
            axis_in_tready[i] = locked && (grant_q == GW'(i)) && axis_out_tready;
    end

    assign axis_out_tvalid = locked && axis_in_tvalid[grant_q];
    assign axis_out_tlast  = locked && axis_in_tlast[grant_q];
    assign axis_out_tdata  = axis_in_tdata[grant_q];
    assign axis_out_tdest  = axis_in_tdest[grant_q];
    assign axis_out_tid    = axis_in_tid[grant_q];
    assign grant_id        = grant_q;
    assign busy            = locked;

    for (genvar g = 0; g < NUM_IN; g++) begin : g_cnt
        axis_pkt_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (tlast_hs && (grant_q == GW'(g))),
            .count (pkt_count[g])
        );
    end
endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Scoreboard bench for axis_packet_arbiter: per-requester beat queues drive the
// inputs, expected output beats are queued in predicted grant order and checked by a monitor.

module tb_axis_packet_arbiter;
    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int DEW = 2;
    localparam int IW  = 2;
    localparam int CW  = 2;

    typedef struct packed {
        logic          v;
        logic [DW-1:0] data;
        logic [DEW-1:0] dest;
        logic [IW-1:0] id;
        logic          last;
    } beat_t;

    typedef struct {
        int             src;
        logic [DW-1:0]  data;
        logic [DEW-1:0] dest;
        logic [IW-1:0]  id;
        logic           last;
        int             gap;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           in_tvalid [N];
    logic           in_tready [N];
    logic           in_tlast  [N];
    logic [DW-1:0]  in_tdata  [N];
    logic [DEW-1:0] in_tdest  [N];
    logic [IW-1:0]  in_tid    [N];
    logic           out_tvalid;
    logic           out_tready;
    logic [DW-1:0]  out_tdata;
    logic           out_tlast;
    logic [DEW-1:0] out_tdest;
    logic [IW-1:0]  out_tid;
    logic [1:0]     grant_id;
    logic           busy;
    logic [CW-1:0]  pkt_count [N];

    axis_packet_arbiter #(
        .NUM_IN(N), .TDATA_WIDTH(DW), .TDEST_WIDTH(DEW), .TID_WIDTH(IW), .COUNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .axis_in_tvalid(in_tvalid), .axis_in_tready(in_tready), .axis_in_tlast(in_tlast),
        .axis_in_tdata(in_tdata), .axis_in_tdest(in_tdest), .axis_in_tid(in_tid),
        .axis_out_tvalid(out_tvalid), .axis_out_tready(out_tready), .axis_out_tdata(out_tdata),
        .axis_out_tlast(out_tlast), .axis_out_tdest(out_tdest), .axis_out_tid(out_tid),
        .grant_id(grant_id), .busy(busy), .pkt_count(pkt_count)
    );

    beat_t inq [N][$];
    exp_t  sb [$];
    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    int    last_tl = 0;
    bit    rdy_mode = 1'b0;
    logic  fire [N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] tready_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = in_tready[i];
        return v;
    endfunction

    function automatic logic [N*CW-1:0] cnt_vec();
        logic [N*CW-1:0] v;
        for (int i = 0; i < N; i++) v[i*CW +: CW] = pkt_count[i];
        return v;
    endfunction

    // Requester drivers: a beat leaves its queue on handshake; idle entries last one cycle.
    initial begin
        for (int i = 0; i < N; i++) begin
            in_tvalid[i] = 1'b0; in_tlast[i] = 1'b0;
            in_tdata[i] = '0; in_tdest[i] = '0; in_tid[i] = '0;
        end
        out_tready = 1'b1;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) fire[i] = in_tvalid[i] && in_tready[i];
            @(posedge clk);
            for (int i = 0; i < N; i++)
                if (rst_n && inq[i].size() > 0 && (fire[i] || !inq[i][0].v))
                    void'(inq[i].pop_front());
            #1;
            for (int i = 0; i < N; i++) begin
                if (inq[i].size() > 0) begin
                    in_tvalid[i] = inq[i][0].v;
                    in_tdata[i]  = inq[i][0].data;
                    in_tdest[i]  = inq[i][0].dest;
                    in_tid[i]    = inq[i][0].id;
                    in_tlast[i]  = inq[i][0].last;
                end else begin
                    in_tvalid[i] = 1'b0;
                    in_tlast[i]  = 1'b0;
                end
            end
            out_tready = rdy_mode ? !out_tready : 1'b1;
        end
    end

    // Monitor: owner must match the head of the scoreboard; each output handshake pops one beat.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (busy && sb.size() > 0) chk("grant_hold", grant_id, sb[0].src);
                if (out_tvalid && out_tready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_beat", out_tdata, 64'hDEAD);
                    end else begin
                        e = sb.pop_front();
                        chk("beat_grant", grant_id, e.src);
                        chk("beat_tdata", out_tdata, e.data);
                        chk("beat_tdest", out_tdest, e.dest);
                        chk("beat_tid", out_tid, e.id);
                        chk("beat_tlast", out_tlast, e.last);
                        chk("beat_tready", tready_vec(), 64'(1) << e.src);
                        if (e.last) begin
                            if (e.gap != 0) chk("pkt_spacing", cyc - last_tl, e.gap);
                            last_tl = cyc;
                        end
                    end
                end
            end
        end
    end

    task automatic idle(input int src, input int n);
        beat_t b;
        b = '0;
        for (int k = 0; k < n; k++) inq[src].push_back(b);
    endtask

    // Queue an n-beat packet; only the first n_exp beats are expected at the output.
    task automatic send_pkt(input int src, input int n, input int n_exp, input logic [DW-1:0] base,
                            input int gap, input int hole_at, input int hole_len);
        beat_t b;
        exp_t  e;
        for (int k = 0; k < n; k++) begin
            if (k == hole_at) idle(src, hole_len);
            b.v = 1'b1; b.data = base + DW'(k); b.dest = DEW'(src + k);
            b.id = IW'(3 - src); b.last = (k == n - 1);
            inq[src].push_back(b);
            if (k < n_exp) begin
                e.src = src; e.data = b.data; e.dest = b.dest; e.id = b.id;
                e.last = b.last; e.gap = b.last ? gap : 0;
                sb.push_back(e);
            end
        end
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        rdy_mode = 1'b0;
        sb.delete();
        for (int i = 0; i < N; i++) inq[i].delete();
        repeat (2) @(posedge clk);
        #3;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic wait_sb(input string nm, input int left, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(posedge clk);
            #2;
            if (sb.size() <= left) return;
        end
        tests++; fails++;
        $display("FAIL %s: timeout, %0d beats pending, required %0d", nm, sb.size(), left);
    endtask

    task automatic wait_done(input string nm, input int budget);
        int pend;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk);
            #2;
            pend = sb.size();
            for (int i = 0; i < N; i++) pend += inq[i].size();
            if (pend == 0) return;
        end
        tests++; fails++;
        $display("FAIL %s: timeout, %0d entries pending, required 0", nm, sb.size());
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_tvalid"}, out_tvalid, 0);
        chk({nm, "_tready"}, tready_vec(), 0);
        chk({nm, "_grant"}, grant_id, 0);
        chk({nm, "_cnt"}, cnt_vec(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Four requesters with 3-beat packets, requester 0 has a second one queued.
        do_reset();
        chk_reset_state("reset");
        send_pkt(0, 3, 3, 32'h0000_0100, 0, -1, 0);
        send_pkt(1, 3, 3, 32'h0000_0200, 4, -1, 0);
        send_pkt(2, 3, 3, 32'h0000_0300, 4, -1, 0);
        send_pkt(3, 3, 3, 32'h0000_0400, 4, -1, 0);
        send_pkt(0, 3, 3, 32'h0000_0500, 4, -1, 0);
        release_reset();
        @(posedge clk); #2;
        chk("no_grant_first_edge", busy, 0);
        @(posedge clk); #2;
        chk("grant_second_edge", busy, 1);
        chk("first_grant_id", grant_id, 0);
        wait_sb("rr_four", 3, 100);
        chk("cnt_after_four", cnt_vec(), 8'h55);
        wait_done("rr_done", 100);
        chk("cnt_rr_end", cnt_vec(), 8'h56);

        // Requester 2 drops tvalid mid-packet while requester 0 waits.
        do_reset();
        idle(0, 2);
        send_pkt(2, 5, 5, 32'hA000_0000, 0, 2, 2);
        send_pkt(0, 2, 2, 32'hB000_0000, 0, -1, 0);
        release_reset();
        wait_done("hold_done", 100);
        chk("cnt_hold", cnt_vec(), 8'h11);

        // Downstream ready toggling every cycle.
        do_reset();
        rdy_mode = 1'b1;
        send_pkt(1, 4, 4, 32'hC0DE_0000, 0, -1, 0);
        release_reset();
        wait_done("toggle_done", 100);
        chk("cnt_toggle", cnt_vec(), 8'h04);
        rdy_mode = 1'b0;

        // Counter saturation with single-beat packets.
        do_reset();
        for (int p = 0; p < 5; p++)
            send_pkt(1, 1, 1, 32'h5000_0000 + DW'(p), (p == 0) ? 0 : 2, -1, 0);
        release_reset();
        wait_sb("sat_three", 2, 100);
        chk("cnt_sat_third", pkt_count[1], 3);
        wait_done("sat_done", 100);
        chk("cnt_sat_end", pkt_count[1], 3);
        chk("cnt_sat_vec", cnt_vec(), 8'h0C);

        // Reset during beat 2 of a requester-3 packet.
        do_reset();
        idle(0, 2);
        send_pkt(3, 4, 2, 32'hD000_0000, 0, -1, 0);
        send_pkt(0, 2, 2, 32'hE000_0000, 0, -1, 0);
        release_reset();
        wait_sb("midrst_beats", 2, 100);
        chk("midrst_busy_before", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        chk_reset_state("midrst");
        inq[3].delete();
        release_reset();
        wait_done("midrst_done", 100);
        chk("cnt_midrst", cnt_vec(), 8'h01);

        // Only requester 3 valid, back-to-back packets.
        do_reset();
        send_pkt(3, 2, 2, 32'hF000_0000, 0, -1, 0);
        send_pkt(3, 2, 2, 32'hF100_0000, 3, -1, 0);
        send_pkt(3, 2, 2, 32'hF200_0000, 3, -1, 0);
        release_reset();
        wait_done("solo_done", 100);
        chk("cnt_solo", cnt_vec(), 8'hC0);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/axis_packet_arbiter.md
AXIS_PACKET_ARBITER -- requirements
Module: axis_packet_arbiter

Interface
REQ-001 SHALL have parameter NUM_IN, default 4, number of AXI-Stream requesters (1..16).
REQ-002 SHALL have parameter TDATA_WIDTH, default 32, data width.
REQ-003 SHALL have parameter TDEST_WIDTH, default 2, tdest width.
REQ-004 SHALL have parameter TID_WIDTH, default 2, tid width.
REQ-005 SHALL have parameter COUNT_WIDTH, default 16, per-requester packet counter width.
REQ-006 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have ports axis_in_tvalid/tready/tlast  input/output/input  1 each, unpacked [NUM_IN]  requester streams.
REQ-009 SHALL have ports axis_in_tdata/tdest/tid  input  TDATA_WIDTH/TDEST_WIDTH/TID_WIDTH, unpacked [NUM_IN]  requester payload.
REQ-010 SHALL have ports axis_out_tvalid/tready/tdata/tlast/tdest/tid  output/input/output/output/output/output  matching widths  shared stream toward one mesh input port.
REQ-011 SHALL have port grant_id  output  $clog2(NUM_IN) (min 1)  index of current owner.
REQ-012 SHALL have port busy  output  1  high while a packet is locked.
REQ-013 SHALL have port pkt_count  output  COUNT_WIDTH, unpacked [NUM_IN]  completed packets per requester.

Function
REQ-014 SHALL implement two states: IDLE, LOCKED.
REQ-015 IDLE: axis_out_tvalid=0, all axis_in_tready=0, busy=0.
REQ-016 IDLE with any axis_in_tvalid high: select first valid index searching ptr, ptr+1, ... mod NUM_IN; register grant_id; enter LOCKED next cycle (1-cycle arbitration latency).
REQ-017 IDLE with no valid: stay IDLE; grant_id holds last value.
REQ-018 LOCKED: axis_out_* payload/tvalid/tlast = axis_in_*[grant_id] combinationally; axis_in_tready[grant_id] = axis_out_tready; all other axis_in_tready = 0; busy=1.
REQ-019 LOCKED SHALL hold grant until handshake (tvalid&tready) with tlast=1 on the granted input, regardless of granted tvalid dropping mid-packet or other requesters asserting.
REQ-020 On tlast handshake: next state IDLE; ptr <= (grant_id+1) mod NUM_IN; pkt_count[grant_id] increments.
REQ-021 One idle bubble cycle SHALL follow each packet (max throughput: packet length + 1 cycles per packet).
REQ-022 pkt_count SHALL saturate at 2**COUNT_WIDTH-1, never wrap.
REQ-023 Single-beat packet (tlast on first beat) SHALL be one LOCKED cycle when tready high.
REQ-024 NUM_IN=1: ptr stays 0; behaviour otherwise identical.
REQ-025 Combinational paths in->out only through the LOCKED mux; no path from axis_in_tvalid to any axis_in_tready.
REQ-026 Payload SHALL not be modified; tdest/tid pass through unchanged.

Reset
REQ-027 While rst_n=0: state IDLE, ptr 0, grant_id 0, all pkt_count 0, busy 0, axis_out_tvalid 0, all axis_in_tready 0.
REQ-028 Reset asserted mid-packet SHALL abandon the packet immediately (asynchronous); after release arbitration restarts from ptr 0.
REQ-029 No grant SHALL be issued in the first rising edge where rst_n samples 0->1 transition; arbitration begins on following edge.

Verification
REQ-030 NUM_IN=4, all four requesters valid with 3-beat packets, tready=1 -> grants 0,1,2,3,0 in order; each packet 4 cycles incl. bubble; pkt_count={1,1,1,1} after 16 cycles.
REQ-031 Requester 2 sends 5-beat packet, drops tvalid on beats 2-3 while requester 0 valid -> grant_id stays 2 until tlast handshake; requester 0 granted next.
REQ-032 axis_out_tready toggled 1/0 each cycle during 4-beat packet -> exactly 4 beats transferred, no duplication/loss, tdata/tdest/tid match source.
REQ-033 COUNT_WIDTH=2, requester 1 alone sends 5 single-beat packets -> pkt_count[1]=3 after 3rd and stays 3.
REQ-034 rst_n pulsed low during beat 2 of requester 3 packet -> outputs reset immediately; after release requester 0 (valid) granted first, pkt_count all 0.
REQ-035 Only requester 3 valid repeatedly, ptr=0 -> granted each time with one bubble; no grant to invalid requesters.
